// File: rtl/ysyx_23060062_rv32_idu.sv
// ysyx_23060062_rv32_idu: instruction decode stage feeding ysyx_23060062_rv32_alu.
// Takes 32-bit fetch words, turns them into instructions and decodes each into
// opcode one-hot, format type, funct3 one-hot, funct7, register indices and
// sign-extended immediate. All id_* outputs are registered.
//
// Optional feature macro: RVC_EN. When defined, a halfword aligner splits and
// joins fetch words so 16-bit parcels and straddling 32-bit instructions are
// emitted in order.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush, flush_pc     redirect: drop everything buffered; flush_pc[1] picks
//                       the starting halfword (RVC_EN only)
//   if_valid/if_ready   fetch word handshake; if_pc word address, if_data word
//   id_valid/id_ready   decoded instruction handshake
//   id_pc, id_inst      instruction address and raw bits ({16'h0,parcel} if C)
//   id_en, id_type      one-hot of inst[6:2]; format 0 R,1 I,2 S,3 B,4 U,5 J,7 none
//   id_funct3_en        one-hot of inst[14:12] for R/I/S/B
//   id_funct7           inst[31:25] for R
//   id_rs1/rs2/rd       register fields, zero where the format lacks them
//   id_imm              sign-extended immediate
//   id_is_c, id_illegal 16-bit parcel flag; unsupported encoding flag
module ysyx_23060062_rv32_idu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_en,
  output logic [2:0]  id_type,
  output logic [7:0]  id_funct3_en,
  output logic [6:0]  id_funct7,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_imm,
  output logic        id_is_c,
  output logic        id_illegal
);

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [2:0] TY_R    = 3'd0;
  localparam logic [2:0] TY_I    = 3'd1;
  localparam logic [2:0] TY_S    = 3'd2;
  localparam logic [2:0] TY_B    = 3'd3;
  localparam logic [2:0] TY_U    = 3'd4;
  localparam logic [2:0] TY_J    = 3'd5;
  localparam logic [2:0] TY_NONE = 3'd7;

  // Output register can take a new instruction this cycle.
  logic free_c;
  assign free_c = !id_valid || id_ready;

  // Instruction presented to the output register this cycle.
  logic            emit_c;
  logic [XLEN-1:0] inst_c;
  logic [XLEN-1:0] pc_c;
  logic            is_c_c;

`ifdef RVC_EN
  typedef enum logic [1:0] {EMPTY, HALF_C, HALF_LO, SKIP} align_state_e;

  align_state_e state, state_nxt;
  logic [15:0]     hold_buf, hold_buf_nxt;
  logic [XLEN-1:0] hold_pc, hold_pc_nxt;
  logic            accept_c;
  logic            hi_is_c_c;
  logic [XLEN-1:0] hi_pc_c;
  logic            unused_c;

  assign unused_c  = ^{flush_pc[31:2], flush_pc[0]};
  assign if_ready  = rst_n && !flush && free_c && (state != HALF_C);
  assign accept_c  = if_valid && if_ready;
  assign hi_is_c_c = (if_data[17:16] != 2'b11);
  assign hi_pc_c   = if_pc + 32'd2;

  // Aligner state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      hold_buf <= '0;
      hold_pc  <= '0;
    end else begin
      state    <= state_nxt;
      hold_buf <= hold_buf_nxt;
      hold_pc  <= hold_pc_nxt;
    end
  end

  // Aligner next state and emitted instruction.
  always_comb begin
    state_nxt    = state;
    hold_buf_nxt = hold_buf;
    hold_pc_nxt  = hold_pc;
    emit_c       = 1'b0;
    inst_c       = '0;
    pc_c         = if_pc;
    is_c_c       = 1'b0;
    if (flush) begin
      state_nxt = flush_pc[1] ? SKIP : EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept_c) begin
          emit_c = 1'b1;
          if (if_data[1:0] != 2'b11) begin
            inst_c       = {16'h0, if_data[15:0]};
            is_c_c       = 1'b1;
            hold_buf_nxt = if_data[31:16];
            hold_pc_nxt  = hi_pc_c;
            state_nxt    = hi_is_c_c ? HALF_C : HALF_LO;
          end else begin
            inst_c = if_data;
          end
        end
        HALF_C: if (free_c) begin
          emit_c    = 1'b1;
          inst_c    = {16'h0, hold_buf};
          pc_c      = hold_pc;
          is_c_c    = 1'b1;
          state_nxt = EMPTY;
        end
        HALF_LO: if (accept_c) begin
          // Upper half of the straddling instruction arrives in the low half.
          emit_c       = 1'b1;
          inst_c       = {if_data[15:0], hold_buf};
          pc_c         = hold_pc;
          hold_buf_nxt = if_data[31:16];
          hold_pc_nxt  = hi_pc_c;
          state_nxt    = hi_is_c_c ? HALF_C : HALF_LO;
        end
        SKIP: if (accept_c) begin
          // Redirect landed on the upper halfword; low half is not executed.
          if (hi_is_c_c) begin
            emit_c    = 1'b1;
            inst_c    = {16'h0, if_data[31:16]};
            pc_c      = hi_pc_c;
            is_c_c    = 1'b1;
            state_nxt = EMPTY;
          end else begin
            hold_buf_nxt = if_data[31:16];
            hold_pc_nxt  = hi_pc_c;
            state_nxt    = HALF_LO;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end
`else
  logic unused_c;
  assign unused_c = ^flush_pc;
  assign if_ready = rst_n && !flush && free_c;
  assign emit_c   = if_valid && if_ready;
  assign inst_c   = if_data;
  assign pc_c     = if_pc;
  assign is_c_c   = 1'b0;
`endif

  // Field decode of the emitted instruction.
  logic [4:0]      op_c;
  logic [XLEN-1:0] d_en_c;
  logic [2:0]      d_type_c;
  logic [7:0]      d_f3_c;
  logic [6:0]      d_f7_c;
  logic [4:0]      d_rs1_c, d_rs2_c, d_rd_c;
  logic [XLEN-1:0] d_imm_c;
  logic            d_ill_c;

  assign op_c = inst_c[6:2];

  always_comb begin
    d_en_c   = '0;
    d_type_c = TY_NONE;
    d_f3_c   = '0;
    d_f7_c   = '0;
    d_rs1_c  = '0;
    d_rs2_c  = '0;
    d_rd_c   = '0;
    d_imm_c  = '0;
    d_ill_c  = 1'b0;
    if (!is_c_c) begin
      d_en_c[op_c] = 1'b1;
      if (inst_c[1:0] != 2'b11) begin
        d_ill_c = 1'b1;
      end else begin
        unique case (op_c)
          OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: d_type_c = TY_I;
          OP_AUIPC, OP_LUI:                    d_type_c = TY_U;
          OP_STORE:                            d_type_c = TY_S;
          OP_OP:                               d_type_c = TY_R;
          OP_BRANCH:                           d_type_c = TY_B;
          OP_JAL:                              d_type_c = TY_J;
          default:                             d_ill_c  = 1'b1;
        endcase
      end
      unique case (d_type_c)
        TY_R: begin
          d_f3_c[inst_c[14:12]] = 1'b1;
          d_f7_c  = inst_c[31:25];
          d_rs1_c = inst_c[19:15];
          d_rs2_c = inst_c[24:20];
          d_rd_c  = inst_c[11:7];
        end
        TY_I: begin
          d_f3_c[inst_c[14:12]] = 1'b1;
          d_rs1_c = inst_c[19:15];
          d_rd_c  = inst_c[11:7];
          d_imm_c = {{20{inst_c[31]}}, inst_c[31:20]};
        end
        TY_S: begin
          d_f3_c[inst_c[14:12]] = 1'b1;
          d_rs1_c = inst_c[19:15];
          d_rs2_c = inst_c[24:20];
          d_imm_c = {{20{inst_c[31]}}, inst_c[31:25], inst_c[11:7]};
        end
        TY_B: begin
          d_f3_c[inst_c[14:12]] = 1'b1;
          d_rs1_c = inst_c[19:15];
          d_rs2_c = inst_c[24:20];
          d_imm_c = {{19{inst_c[31]}}, inst_c[31], inst_c[7], inst_c[30:25], inst_c[11:8], 1'b0};
        end
        TY_U: begin
          d_rd_c  = inst_c[11:7];
          d_imm_c = {inst_c[31:12], 12'h0};
        end
        TY_J: begin
          d_rd_c  = inst_c[11:7];
          d_imm_c = {{11{inst_c[31]}}, inst_c[31], inst_c[19:12], inst_c[20], inst_c[30:21], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // Output register: flush drops it, otherwise it loads whenever it is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid     <= 1'b0;
      id_pc        <= RESET_PC;
      id_inst      <= '0;
      id_en        <= '0;
      id_type      <= '0;
      id_funct3_en <= '0;
      id_funct7    <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_imm       <= '0;
      id_is_c      <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (free_c) begin
      id_valid <= emit_c;
      if (emit_c) begin
        id_pc        <= pc_c;
        id_inst      <= inst_c;
        id_en        <= d_en_c;
        id_type      <= d_type_c;
        id_funct3_en <= d_f3_c;
        id_funct7    <= d_f7_c;
        id_rs1       <= d_rs1_c;
        id_rs2       <= d_rs2_c;
        id_rd        <= d_rd_c;
        id_imm       <= d_imm_c;
        id_is_c      <= is_c_c;
        id_illegal   <= d_ill_c;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060062_rv32_idu.sv
// Bench for ysyx_23060062_rv32_idu: directed literal checks followed by a
// randomized stream checked every cycle against a queue-based reference model.
module tb_ysyx_23060062_rv32_idu;

  logic        clk, rst_n, flush, if_valid, if_ready, id_valid, id_ready;
  logic [31:0] flush_pc, if_pc, if_data;
  logic [31:0] id_pc, id_inst, id_en, id_imm;
  logic [2:0]  id_type;
  logic [7:0]  id_funct3_en;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_is_c, id_illegal;

  ysyx_23060062_rv32_idu dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_data(if_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_en(id_en), .id_type(id_type), .id_funct3_en(id_funct3_en),
    .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_is_c(id_is_c), .id_illegal(id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: complete instructions awaiting consumption, and
  // the halfword stream not yet forming an instruction.
  typedef struct { logic [31:0] inst; logic [31:0] pc; bit c; } item_t;
  typedef struct { logic [15:0] h; logic [31:0] pc; } half_t;
  typedef struct {
    logic [31:0] en; logic [2:0] ty; logic [7:0] f3; logic [6:0] f7;
    logic [4:0] rs1, rs2, rd; logic [31:0] imm; bit ill;
  } dec_t;

  item_t q[$];
  half_t halves[$];
  bit    skip_lo = 1'b0;

  function automatic logic [2:0] fmt_of(input logic [4:0] op);
    case (op)
      5'h00, 5'h04, 5'h19, 5'h1c: return 3'd1;
      5'h05, 5'h0d:               return 3'd4;
      5'h08:                      return 3'd2;
      5'h0c:                      return 3'd0;
      5'h18:                      return 3'd3;
      5'h1b:                      return 3'd5;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic dec_t model_dec(input logic [31:0] w, input bit c);
    dec_t d;
    logic [31:0] sx20, sx11;
    d = '{default: '0};
    d.ty = 3'd7;
    if (c) return d;
    d.en  = 32'd1 << w[6:2];
    d.ty  = (w[1:0] == 2'b11) ? fmt_of(w[6:2]) : 3'd7;
    d.ill = (d.ty == 3'd7);
    sx20  = 32'($signed(w) >>> 20);
    sx11  = 32'($signed(w) >>> 11);
    if (d.ty <= 3'd3) d.f3 = 8'd1 << w[14:12];
    if (d.ty == 3'd0) d.f7 = w[31:25];
    if (d.ty <= 3'd3) d.rs1 = w[19:15];
    if (d.ty == 3'd0 || d.ty == 3'd2 || d.ty == 3'd3) d.rs2 = w[24:20];
    if (d.ty == 3'd0 || d.ty == 3'd1 || d.ty == 3'd4 || d.ty == 3'd5) d.rd = w[11:7];
    case (d.ty)
      3'd1: d.imm = sx20;
      3'd2: d.imm = (sx20 & 32'hFFFF_FFE0) | {27'h0, w[11:7]};
      3'd3: d.imm = (sx20 & 32'hFFFF_F7E0) | ({28'h0, w[11:8]} << 1) | ({31'h0, w[7]} << 11);
      3'd4: d.imm = w & 32'hFFFF_F000;
      3'd5: d.imm = (sx11 & 32'hFFF0_0000) | (w & 32'h000F_F000) |
                    ({31'h0, w[20]} << 11) | ({22'h0, w[30:21]} << 1);
      default: d.imm = 32'h0;
    endcase
    return d;
  endfunction

  task automatic cmp_item(input item_t it);
    dec_t d;
    d = model_dec(it.inst, it.c);
    check("id_pc", id_pc, it.pc);
    check("id_inst", id_inst, it.inst);
    check("id_en", id_en, d.en);
    check("id_type", 32'(id_type), 32'(d.ty));
    check("id_funct3_en", 32'(id_funct3_en), 32'(d.f3));
    check("id_funct7", 32'(id_funct7), 32'(d.f7));
    check("id_rs1", 32'(id_rs1), 32'(d.rs1));
    check("id_rs2", 32'(id_rs2), 32'(d.rs2));
    check("id_rd", 32'(id_rd), 32'(d.rd));
    check("id_imm", id_imm, d.imm);
    check("id_is_c", 32'(id_is_c), 32'(it.c));
    check("id_illegal", 32'(id_illegal), 32'(d.ill));
  endtask

  task automatic model_accept(input logic [31:0] w, input logic [31:0] pc);
    item_t it;
    half_t a;
    if (!RVC) begin
      it.inst = w; it.pc = pc; it.c = 1'b0;
      q.push_back(it);
      return;
    end
    if (!skip_lo) begin
      a.h = w[15:0]; a.pc = pc;
      halves.push_back(a);
    end
    skip_lo = 1'b0;
    a.h = w[31:16]; a.pc = pc + 32'd2;
    halves.push_back(a);
    while (halves.size() > 0) begin
      if (halves[0].h[1:0] != 2'b11) begin
        it.inst = {16'h0, halves[0].h}; it.pc = halves[0].pc; it.c = 1'b1;
        q.push_back(it);
        void'(halves.pop_front());
      end else if (halves.size() >= 2) begin
        it.inst = {halves[1].h, halves[0].h}; it.pc = halves[0].pc; it.c = 1'b0;
        q.push_back(it);
        void'(halves.pop_front());
        void'(halves.pop_front());
      end else begin
        break;
      end
    end
  endtask

  // Compare and advance the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = rst_n && !flush && (q.size() == 0 || id_ready) && (!RVC || q.size() < 2);
    check("if_ready", 32'(if_ready), 32'(exp_rdy));
    check("id_valid", 32'(id_valid), 32'(q.size() != 0));
    if (id_valid && q.size() != 0) cmp_item(q[0]);
    if (!rst_n) begin
      q.delete(); halves.delete(); skip_lo = 1'b0;
    end else if (flush) begin
      q.delete(); halves.delete(); skip_lo = RVC && flush_pc[1];
    end else begin
      if (q.size() != 0 && id_ready) void'(q.pop_front());
      if (if_valid && exp_rdy) model_accept(if_data, if_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [4:0]  op;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: op = 5'h00; 1: op = 5'h04; 2: op = 5'h05; 3: op = 5'h08; 4: op = 5'h0c;
      5: op = 5'h0d; 6: op = 5'h18; 7: op = 5'h19; 8: op = 5'h1b; default: op = 5'h1c;
    endcase
    if ($urandom_range(0, 3) != 0) w[6:0] = {op, 2'b11};
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; id_ready = 1'b1;
    if_valid = 1'b1; if_pc = 32'h8000_0000; if_data = 32'h0050_0093;
    repeat (3) @(posedge clk);
    #1;
    check("rst_if_ready", 32'(if_ready), 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_pc", id_pc, 32'h8000_0000);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_id_imm", id_imm, 32'h0);

    rst_n = 1'b1;
    step();
    check("addi_valid", 32'(id_valid), 32'h1);
    check("addi_en", id_en, 32'h0000_0010);
    check("addi_type", 32'(id_type), 32'h1);
    check("addi_f3", 32'(id_funct3_en), 32'h01);
    check("addi_rd", 32'(id_rd), 32'h1);
    check("addi_rs1", 32'(id_rs1), 32'h0);
    check("addi_imm", id_imm, 32'h5);

    // Back-pressure: output holds, no word accepted.
    id_ready = 1'b0; if_data = 32'h0000_007F; if_pc = 32'h8000_0004;
    repeat (4) begin
      step();
      check("stall_if_ready", 32'(if_ready), 32'h0);
      check("stall_inst", id_inst, 32'h0050_0093);
    end
    id_ready = 1'b1;
    step();
    check("ill_flag", 32'(id_illegal), 32'h1);
    check("ill_en", id_en, 32'h8000_0000);
    check("ill_type", 32'(id_type), 32'h7);
    if_data = 32'h40B5_0533; if_pc = 32'h8000_0008;
    step();
    check("sub_type", 32'(id_type), 32'h0);
    check("sub_f7", 32'(id_funct7), 32'h20);
    check("sub_rs2", 32'(id_rs2), 32'hB);

    // Flush drops the word presented in the same cycle.
    flush = 1'b1; if_data = 32'h00A0_0113; if_pc = 32'h8000_000C;
    #1;
    check("flush_if_ready", 32'(if_ready), 32'h0);
    step();
    check("flush_id_valid", 32'(id_valid), 32'h0);
    flush = 1'b0; if_data = 32'hFE00_0EE3; if_pc = 32'h8000_0040;
    step();
    check("beq_valid", 32'(id_valid), 32'h1);
    check("beq_type", 32'(id_type), 32'h3);
    check("beq_imm", id_imm, 32'hFFFF_FFFC);
    check("beq_pc", id_pc, 32'h8000_0040);
    if_valid = 1'b0;
    step();

`ifdef RVC_EN
    if_valid = 1'b1; if_data = 32'h4505_4501; if_pc = 32'h8000_0100;
    step();
    if_valid = 1'b0;
    check("c0_inst", id_inst, 32'h0000_4501);
    check("c0_pc", id_pc, 32'h8000_0100);
    check("c0_is_c", 32'(id_is_c), 32'h1);
    check("c0_if_ready", 32'(if_ready), 32'h0);
    step();
    check("c1_inst", id_inst, 32'h0000_4505);
    check("c1_pc", id_pc, 32'h8000_0102);
    step();
    if_valid = 1'b1; if_data = 32'h0093_4501; if_pc = 32'h8000_0200;
    step();
    check("c2_inst", id_inst, 32'h0000_4501);
    if_data = 32'h0000_0050; if_pc = 32'h8000_0204;
    step();
    if_valid = 1'b0;
    check("s_inst", id_inst, 32'h0050_0093);
    check("s_pc", id_pc, 32'h8000_0202);
    check("s_is_c", 32'(id_is_c), 32'h0);
    step();
`endif

    repeat (3000) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      flush_pc = $urandom;
      if_valid = ($urandom_range(0, 9) < 7);
      if_data  = rand_word();
      if_pc    = $urandom & 32'hFFFF_FFFC;
      id_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    rst_n = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
